// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that funnels NUM_PORTS single-outstanding client ports onto one memory
// controller port. Each request is held in a per-port slot until the controller completes it or it times out.

module mem_port_slot #(
  parameter int AW = 25,
  parameter int DW = 32,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic          rd,
  input  logic          burst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic [BW-1:0] be,
  input  logic          clr,
  output logic          vld,
  output logic          s_wr,
  output logic          s_burst,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_data,
  output logic [BW-1:0] s_be,
  output logic          overrun
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0; s_wr <= 1'b0; s_burst <= 1'b0;
      s_addr <= '0; s_data <= '0; s_be <= '0; overrun <= 1'b0;
    end else begin
      // A strobe against a full slot is dropped, even if the slot clears this cycle.
      if ((wr || rd) && vld) overrun <= 1'b1;
      if (clr) vld <= 1'b0;
      else if ((wr || rd) && !vld) begin
        vld <= 1'b1; s_wr <= wr; s_burst <= burst;
        s_addr <= addr; s_data <= data; s_be <= be;
      end
    end
  end
endmodule

module mem_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   cl_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   cl_data,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] cl_byte_en,
  input  logic [NUM_PORTS-1:0]              cl_wr,
  input  logic [NUM_PORTS-1:0]              cl_rd,
  input  logic [NUM_PORTS-1:0]              cl_burst,
  output logic [DATA_WIDTH-1:0]             cl_q,
  output logic [NUM_PORTS-1:0]              cl_ready,
  output logic [NUM_PORTS-1:0]              cl_available,
  output logic [ADDR_WIDTH-1:0]             mc_addr,
  output logic [DATA_WIDTH-1:0]             mc_data,
  output logic [DATA_WIDTH/8-1:0]           mc_byte_en,
  output logic                              mc_wr,
  output logic                              mc_rd,
  output logic                              mc_burst,
  input  logic [DATA_WIDTH-1:0]             mc_q,
  input  logic                              mc_ready,
  input  logic                              mc_available,
  output logic [NUM_PORTS-1:0]              err_overrun,
  output logic [NUM_PORTS-1:0]              err_timeout
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                               state;
  logic [IW-1:0]                        last, sel;
  logic                                 found, to_hit, done;
  logic [TW-1:0]                        cnt;
  logic [NUM_PORTS-1:0]                 vld, s_wr, s_burst, clr;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] s_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s_data;
  logic [NUM_PORTS-1:0][BW-1:0]         s_be;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
    mem_port_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .BW(BW)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (cl_wr[g]),
      .rd      (cl_rd[g]),
      .burst   (cl_burst[g]),
      .addr    (cl_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .data    (cl_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .be      (cl_byte_en[g*BW +: BW]),
      .clr     (clr[g]),
      .vld     (vld[g]),
      .s_wr    (s_wr[g]),
      .s_burst (s_burst[g]),
      .s_addr  (s_addr[g]),
      .s_data  (s_data[g]),
      .s_be    (s_be[g]),
      .overrun (err_overrun[g])
    );
  end

  assign cl_available = {NUM_PORTS{mc_available}} & ~vld;

  // Round-robin search begins one past the last grant.
  always_comb begin
    found = 1'b0;
    sel   = last;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int j;
      j = (int'(last) + k) % NUM_PORTS;
      if (!found && vld[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  assign to_hit = (TIMEOUT > 0) && (cnt == TW'(TIMEOUT - 1));
  assign done   = (state == WAIT) && (mc_ready || to_hit);
  assign clr    = done ? (NUM_PORTS'(1) << last) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; last <= IW'(NUM_PORTS - 1); cnt <= '0;
      mc_addr <= '0; mc_data <= '0; mc_byte_en <= '0;
      mc_wr <= 1'b0; mc_rd <= 1'b0; mc_burst <= 1'b0;
      cl_q <= '0; cl_ready <= '0; err_timeout <= '0;
    end else begin
      cl_ready <= '0;
      case (state)
        IDLE: if (found && mc_available) begin
          state      <= ISSUE;
          last       <= sel;
          mc_addr    <= s_addr[sel];
          mc_data    <= s_data[sel];
          mc_byte_en <= s_be[sel];
          mc_burst   <= s_burst[sel];
          mc_wr      <= s_wr[sel];
          mc_rd      <= ~s_wr[sel];
        end
        ISSUE: begin
          state <= WAIT;
          mc_wr <= 1'b0;
          mc_rd <= 1'b0;
          cnt   <= '0;
        end
        WAIT: begin
          if (mc_ready) begin
            cl_q     <= mc_q;
            cl_ready <= clr;
            state    <= IDLE;
          end else if (to_hit) begin
            cl_q        <= '0;
            cl_ready    <= clr;
            err_timeout <= err_timeout | clr;
            state       <= IDLE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
